hand_tracker: RTL and testbench
===============================

Name: hand_tracker

Overview:
Parametrised successor to the hand-detection block. It consumes a per-pixel stream of convex-hull and contour data with pixel coordinates, and builds per-frame sums plus a real bounding box of the active contour pixels. At each frame end it decides whether a hand is present and publishes its centre and box. A lost-frame hold-off keeps detection stable across dropped frames. Sits between the contour/hull pipeline and the paddle-control logic, on the VGA pixel clock.

Parameters:
DATA_W, 8, width of hull/contour sample
COORD_W, 11, width of pixel coordinates
ACC_W, 24, width of per-frame sums (saturating)
HAND_THRESHOLD, 100, both sums must exceed this for a detection
PIXEL_THRESHOLD, 16, contour sample >= this marks an active pixel (enters bbox)
MIN_BOX, 8, minimum box width and height, in pixels, inclusive
LOST_FRAMES, 3, consecutive missed frames tolerated before hand_detected drops
SMOOTH_SHIFT, 2, IIR shift for the optional smoothing

Ports:
VGA_CLK  in  1  pixel clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse, first pixel of a frame
frame_end  in  1  one-cycle pulse, last pixel of a frame
pix_valid  in  1  qualifies pix_x, pix_y and both data inputs
pix_x  in  COORD_W  pixel column
pix_y  in  COORD_W  pixel row
convex_hull_data  in  DATA_W  hull sample
contour_data  in  DATA_W  contour sample
hand_detected  out  1  hand present (with hold-off)
hand_x  out  COORD_W  centre x
hand_y  out  COORD_W  centre y
box_x_min, box_x_max, box_y_min, box_y_max  out  COORD_W each  last valid bounding box
result_valid  out  1  one-cycle pulse when outputs are refreshed
frame_err  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: all outputs 0; FSM to IDLE; sums, pixel count and miss counter 0; bbox accumulator at min=all-ones, max=0.
- FSM states: IDLE, ACCUM.
  - IDLE to ACCUM on frame_start.
  - ACCUM to ACCUM on frame_start without a preceding frame_end: pulse frame_err, discard the partial frame, restart accumulation.
  - ACCUM to IDLE on frame_end.
  - frame_end while in IDLE is ignored.
- Accumulation: only when pix_valid and (state==ACCUM or frame_start this cycle).
  - A pixel on the frame_start cycle is the first pixel of the new frame.
  - A pixel on the frame_end cycle is included.
  - Sums saturate at 2^ACC_W-1; no wrap.
  - An active pixel (contour_data >= PIXEL_THRESHOLD) updates the min/max registers and increments the active count (saturating).
- Evaluation is a 2-stage pipeline:
  - At frame_end (cycle N) the accumulators are snapshotted into eval registers.
  - Stage 1 (N+1): compare against the thresholds; compute centres as (min+max)>>1 with COORD_W+1-bit intermediates.
  - Stage 2 (N+2): register the outputs and pulse result_valid.
  - The pipeline runs independently of the FSM, so a frame_start at N+1 or N+2 is legal.
- Detection condition: hull_sum > HAND_THRESHOLD, contour_sum > HAND_THRESHOLD, active_count > 0, (max_x-min_x+1) >= MIN_BOX, and (max_y-min_y+1) >= MIN_BOX.
- On detection:
  - hand_detected = 1, miss_cnt = 0.
  - Centre and box outputs updated.
- On miss:
  - miss_cnt increments, saturating at LOST_FRAMES.
  - Position and box outputs hold.
  - hand_detected = 1 while miss_cnt (after increment) <= LOST_FRAMES-1, otherwise 0.
  - With LOST_FRAMES = 0, a single miss drops detection.
- RST mid-frame: synchronous and immediate; any pending pipeline result is discarded (no result_valid).

Optional Feature:
HAND_TRACKER_SMOOTH_EN
- Defined: on detection, hand_x <= hand_x + ((meas_x - hand_x) >>> SMOOTH_SHIFT), signed arithmetic, same for hand_y. The first detection after hand_detected was 0 loads meas directly. Box outputs are never smoothed. result_valid timing is unchanged.
- Undefined: hand_x/hand_y load meas directly on every detection.

Test Plan:
- Frame with 20x20 active square at x 100..119, y 50..69, contour 200, hull 50 on each active pixel -> result_valid at frame_end+2; hand_detected=1; hand_x=109; hand_y=59; box 100/119/50/69.
- Same frame but a 5x5 square -> sums exceed 100 but box fails MIN_BOX -> hand_detected=0 (from reset); outputs hold 0.
- Detect once, then 3 empty frames, then a 4th empty frame (LOST_FRAMES=3) -> hand_detected stays 1 after misses 1–2, drops to 0 after miss 3; position holds 109/59 throughout.
- frame_start, 10 active pixels, frame_start again, then a 20x20 frame -> frame_err pulses once; result reflects only the second frame.
- All pixels contour=255, hull=255 on a 1024x1024 frame with ACC_W=16 -> sums saturate at 65535 (no wrap); detection asserted.
- With HAND_TRACKER_SMOOTH_EN, SMOOTH_SHIFT=2: detect at x=100, then x=140 -> hand_x=100, then 110.

Source files
------------

// File: rtl/hand_tracker.sv
// Per-frame hand detector: accumulates hull/contour sums and the bounding box of active contour pixels, evaluates each frame in a 2-stage pipeline.
// Optional IIR smoothing of the centre outputs is enabled by defining HAND_TRACKER_SMOOTH_EN.
module hand_tracker #(
    parameter int DATA_W          = 8,
    parameter int COORD_W         = 11,
    parameter int ACC_W           = 24,
    parameter int HAND_THRESHOLD  = 100,
    parameter int PIXEL_THRESHOLD = 16,
    parameter int MIN_BOX         = 8,
    parameter int LOST_FRAMES     = 3,
    parameter int SMOOTH_SHIFT    = 2
) (
    input  logic               VGA_CLK,
    input  logic               RST,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [DATA_W-1:0]  convex_hull_data,
    input  logic [DATA_W-1:0]  contour_data,
    output logic               hand_detected,
    output logic [COORD_W-1:0] hand_x,
    output logic [COORD_W-1:0] hand_y,
    output logic [COORD_W-1:0] box_x_min,
    output logic [COORD_W-1:0] box_x_max,
    output logic [COORD_W-1:0] box_y_min,
    output logic [COORD_W-1:0] box_y_max,
    output logic               result_valid,
    output logic               frame_err
);

    localparam int                 MISS_W     = $clog2(LOST_FRAMES + 1) + 1;
    localparam logic [MISS_W-1:0]  LOST_M     = MISS_W'(LOST_FRAMES);
    localparam logic [ACC_W-1:0]   HAND_TH    = ACC_W'(HAND_THRESHOLD);
    localparam logic [COORD_W:0]   MIN_BOX_W  = (COORD_W + 1)'(MIN_BOX);
    localparam logic [COORD_W:0]   ONE_C      = (COORD_W + 1)'(1);
    localparam logic [ACC_W-1:0]   ONE_A      = ACC_W'(1);

    typedef enum logic [0:0] {IDLE, ACCUM} state_t;
    state_t state, state_nxt;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    logic in_frame, acc_en, pix_active, snap, frame_abort;

    // Handshake: pix_valid qualifies pix_x/pix_y/hull/contour for one cycle; there is no backpressure.
    always_comb begin
        state_nxt   = state;
        frame_abort = 1'b0;
        if (frame_start) begin
            state_nxt   = frame_end ? IDLE : ACCUM;
            frame_abort = (state == ACCUM);
        end else if (frame_end && state == ACCUM) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    assign in_frame   = (state == ACCUM) || frame_start;
    assign acc_en     = pix_valid && in_frame;
    assign pix_active = 32'(contour_data) >= PIXEL_THRESHOLD;
    assign snap       = frame_end && in_frame;

    logic [ACC_W-1:0]   hull_sum, cont_sum, act_cnt;
    logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
    logic [ACC_W-1:0]   hull_sum_n, cont_sum_n, act_cnt_n;
    logic [COORD_W-1:0] min_x_n, max_x_n, min_y_n, max_y_n;

    // A frame_start cycle begins from cleared accumulators so its own pixel counts for the new frame.
    always_comb begin
        hull_sum_n = frame_start ? '0 : hull_sum;
        cont_sum_n = frame_start ? '0 : cont_sum;
        act_cnt_n  = frame_start ? '0 : act_cnt;
        min_x_n    = frame_start ? '1 : min_x;
        max_x_n    = frame_start ? '0 : max_x;
        min_y_n    = frame_start ? '1 : min_y;
        max_y_n    = frame_start ? '0 : max_y;
        if (acc_en) begin
            hull_sum_n = sat_add(hull_sum_n, {{(ACC_W - DATA_W){1'b0}}, convex_hull_data});
            cont_sum_n = sat_add(cont_sum_n, {{(ACC_W - DATA_W){1'b0}}, contour_data});
            if (pix_active) begin
                act_cnt_n = sat_add(act_cnt_n, ONE_A);
                if (pix_x < min_x_n) min_x_n = pix_x;
                if (pix_x > max_x_n) max_x_n = pix_x;
                if (pix_y < min_y_n) min_y_n = pix_y;
                if (pix_y > max_y_n) max_y_n = pix_y;
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            hull_sum <= '0;
            cont_sum <= '0;
            act_cnt  <= '0;
            min_x    <= '1;
            max_x    <= '0;
            min_y    <= '1;
            max_y    <= '0;
        end else if (in_frame) begin
            hull_sum <= hull_sum_n;
            cont_sum <= cont_sum_n;
            act_cnt  <= act_cnt_n;
            min_x    <= min_x_n;
            max_x    <= max_x_n;
            min_y    <= min_y_n;
            max_y    <= max_y_n;
        end
    end

    logic               eval_valid;
    logic [ACC_W-1:0]   eval_hull, eval_cont, eval_cnt;
    logic [COORD_W-1:0] eval_min_x, eval_max_x, eval_min_y, eval_max_y;

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            eval_valid <= 1'b0;
            eval_hull  <= '0;
            eval_cont  <= '0;
            eval_cnt   <= '0;
            eval_min_x <= '1;
            eval_max_x <= '0;
            eval_min_y <= '1;
            eval_max_y <= '0;
        end else begin
            eval_valid <= snap;
            if (snap) begin
                eval_hull  <= hull_sum_n;
                eval_cont  <= cont_sum_n;
                eval_cnt   <= act_cnt_n;
                eval_min_x <= min_x_n;
                eval_max_x <= max_x_n;
                eval_min_y <= min_y_n;
                eval_max_y <= max_y_n;
            end
        end
    end

    logic [COORD_W:0]   box_w, box_h, cx_sum, cy_sum;
    logic [COORD_W-1:0] meas_x, meas_y, new_x, new_y;
    logic [MISS_W-1:0]  miss_cnt, miss_inc;
    logic               det, det_hold;

    always_comb begin
        box_w    = {1'b0, eval_max_x} - {1'b0, eval_min_x} + ONE_C;
        box_h    = {1'b0, eval_max_y} - {1'b0, eval_min_y} + ONE_C;
        cx_sum   = {1'b0, eval_min_x} + {1'b0, eval_max_x};
        cy_sum   = {1'b0, eval_min_y} + {1'b0, eval_max_y};
        meas_x   = cx_sum[COORD_W:1];
        meas_y   = cy_sum[COORD_W:1];
        det      = (eval_hull > HAND_TH) && (eval_cont > HAND_TH) && (eval_cnt != '0) &&
                   (box_w >= MIN_BOX_W) && (box_h >= MIN_BOX_W);
        miss_inc = (miss_cnt >= LOST_M) ? LOST_M : miss_cnt + MISS_W'(1);
        // The hold-off only sustains a detection that already exists.
        det_hold = hand_detected && (miss_inc < LOST_M);
    end

`ifdef HAND_TRACKER_SMOOTH_EN
    logic signed [COORD_W+1:0] diff_x, diff_y, step_x, step_y;
    always_comb begin
        diff_x = $signed({2'b00, meas_x}) - $signed({2'b00, hand_x});
        diff_y = $signed({2'b00, meas_y}) - $signed({2'b00, hand_y});
        step_x = diff_x >>> SMOOTH_SHIFT;
        step_y = diff_y >>> SMOOTH_SHIFT;
        new_x  = hand_detected ? hand_x + step_x[COORD_W-1:0] : meas_x;
        new_y  = hand_detected ? hand_y + step_y[COORD_W-1:0] : meas_y;
    end
`else
    always_comb begin
        new_x = meas_x;
        new_y = meas_y;
    end
`endif

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            hand_detected <= 1'b0;
            hand_x        <= '0;
            hand_y        <= '0;
            box_x_min     <= '0;
            box_x_max     <= '0;
            box_y_min     <= '0;
            box_y_max     <= '0;
            result_valid  <= 1'b0;
            frame_err     <= 1'b0;
            miss_cnt      <= '0;
        end else begin
            result_valid <= eval_valid;
            frame_err    <= frame_abort;
            if (eval_valid) begin
                if (det) begin
                    hand_detected <= 1'b1;
                    miss_cnt      <= '0;
                    hand_x        <= new_x;
                    hand_y        <= new_y;
                    box_x_min     <= eval_min_x;
                    box_x_max     <= eval_max_x;
                    box_y_min     <= eval_min_y;
                    box_y_max     <= eval_max_y;
                end else begin
                    miss_cnt      <= miss_inc;
                    hand_detected <= det_hold;
                end
            end
        end
    end

endmodule

// File: tb/tb_hand_tracker.sv
// Directed bench for hand_tracker (ACC_W=16 so saturation is reachable in a short frame).
module tb_hand_tracker;
    localparam int CW = 11;
    localparam int DW = 8;

    logic          VGA_CLK = 1'b0;
    logic          RST, frame_start, frame_end, pix_valid;
    logic [CW-1:0] pix_x, pix_y;
    logic [DW-1:0] convex_hull_data, contour_data;
    logic          hand_detected, result_valid, frame_err;
    logic [CW-1:0] hand_x, hand_y, box_x_min, box_x_max, box_y_min, box_y_max;

    int checks = 0;
    int errors = 0;

    hand_tracker #(.ACC_W(16)) dut (
        .VGA_CLK(VGA_CLK), .RST(RST), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .convex_hull_data(convex_hull_data), .contour_data(contour_data),
        .hand_detected(hand_detected), .hand_x(hand_x), .hand_y(hand_y),
        .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
        .result_valid(result_valid), .frame_err(frame_err)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic px(input logic fs, input logic fe, input logic pv,
                      input int x, input int y, input int c, input int h);
        frame_start      = fs;
        frame_end        = fe;
        pix_valid        = pv;
        pix_x            = CW'(x);
        pix_y            = CW'(y);
        contour_data     = DW'(c);
        convex_hull_data = DW'(h);
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic idle();
        px(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic send_square(input int x0, input int y0, input int sz, input int c, input int h,
                               input logic fe_last, output int err_pulses);
        err_pulses = 0;
        for (int yy = 0; yy < sz; yy++) begin
            for (int xx = 0; xx < sz; xx++) begin
                px((xx == 0 && yy == 0), fe_last && (xx == sz - 1) && (yy == sz - 1), 1'b1,
                   x0 + xx, y0 + yy, c, h);
                if (frame_err) err_pulses++;
            end
        end
    endtask

    // Called right after the edge that sampled frame_end.
    task automatic expect_result(input string tag, input logic det, input int hx, input int hy,
                                 input int bx0, input int bx1, input int by0, input int by1);
        check({tag, "_rv_n1"}, result_valid, 1'b0);
        idle();
        check({tag, "_rv_n2"}, result_valid, 1'b1);
        check({tag, "_det"}, hand_detected, det);
        check({tag, "_hx"}, hand_x, hx);
        check({tag, "_hy"}, hand_y, hy);
        check({tag, "_bxmin"}, box_x_min, bx0);
        check({tag, "_bxmax"}, box_x_max, bx1);
        check({tag, "_bymin"}, box_y_min, by0);
        check({tag, "_bymax"}, box_y_max, by1);
        idle();
        check({tag, "_rv_n3"}, result_valid, 1'b0);
    endtask

    task automatic empty_frame(input string tag, input logic det);
        px(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        px(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        expect_result(tag, det, 109, 59, 100, 119, 50, 69);
    endtask

    initial begin
        int errs;
        RST = 1'b1;
        idle();
        idle();
        idle();
        check("rst_det", hand_detected, 1'b0);
        check("rst_hx", hand_x, 0);
        check("rst_hy", hand_y, 0);
        check("rst_bxmin", box_x_min, 0);
        check("rst_bymax", box_y_max, 0);
        check("rst_rv", result_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        RST = 1'b0;
        idle();

        // 5x5 square: sums pass, box too small
        send_square(100, 50, 5, 200, 50, 1'b1, errs);
        expect_result("small", 1'b0, 0, 0, 0, 0, 0, 0);
        idle();

        // 20x20 square
        send_square(100, 50, 20, 200, 50, 1'b1, errs);
        check("sq20_ferr", errs, 0);
        expect_result("sq20", 1'b1, 109, 59, 100, 119, 50, 69);

        // Lost-frame hold-off
        empty_frame("miss1", 1'b1);
        empty_frame("miss2", 1'b1);
        empty_frame("miss3", 1'b0);
        empty_frame("miss4", 1'b0);

        // Aborted frame then a full frame at a new position
        px(1'b1, 1'b0, 1'b1, 0, 0, 200, 50);
        for (int i = 1; i < 10; i++) px(1'b0, 1'b0, 1'b1, i, 0, 200, 50);
        check("abort_ferr_idle", frame_err, 1'b0);
        send_square(140, 80, 20, 200, 50, 1'b1, errs);
        check("abort_ferr_cnt", errs, 1);
        expect_result("abort", 1'b1, 149, 89, 140, 159, 80, 99);

        // Second detection while tracking
        send_square(100, 50, 20, 200, 50, 1'b1, errs);
`ifdef HAND_TRACKER_SMOOTH_EN
        expect_result("track", 1'b1, 139, 81, 100, 119, 50, 69);
`else
        expect_result("track", 1'b1, 109, 59, 100, 119, 50, 69);
`endif

        // Saturation: true sums 65586 would wrap to 50 at 16 bits
        send_square(100, 50, 16, 255, 255, 1'b0, errs);
        px(1'b0, 1'b0, 1'b1, 100, 50, 255, 255);
        px(1'b0, 1'b1, 1'b1, 100, 50, 51, 51);
`ifdef HAND_TRACKER_SMOOTH_EN
        expect_result("sat", 1'b1, 131, 75, 100, 115, 50, 65);
`else
        expect_result("sat", 1'b1, 107, 57, 100, 115, 50, 65);
`endif

        // frame_end in IDLE is ignored
        px(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        idle();
        check("idle_fe_rv1", result_valid, 1'b0);
        idle();
        check("idle_fe_rv2", result_valid, 1'b0);
        check("idle_fe_det", hand_detected, 1'b1);

        // Reset while a result is in flight
        send_square(200, 200, 20, 200, 50, 1'b1, errs);
        RST = 1'b1;
        idle();
        check("midrst_rv", result_valid, 1'b0);
        check("midrst_det", hand_detected, 1'b0);
        check("midrst_hx", hand_x, 0);
        check("midrst_bxmax", box_x_max, 0);
        RST = 1'b0;
        idle();
        check("midrst_rv2", result_valid, 1'b0);
        idle();
        check("midrst_rv3", result_valid, 1'b0);

        // Pixels on the frame_start and frame_end cycles; contour 15 inactive, 16 active
        px(1'b1, 1'b0, 1'b1, 10, 10, 255, 255);
        px(1'b0, 1'b0, 1'b1, 0, 0, 15, 255);
        px(1'b0, 1'b1, 1'b1, 30, 30, 16, 255);
        expect_result("edge", 1'b1, 20, 20, 10, 30, 10, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not reach the end");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
